stopwatch_counter: RTL and testbench



---
 rtl/stopwatch_pkg.sv | 20 ++
 rtl/stopwatch_counter_bcd.sv | 46 ++++
 rtl/stopwatch_counter.sv | 172 +++++++++++++++++
 tb/tb_stopwatch_counter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch time-keeping stage.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } sw_state_t;

  localparam int BCD_W     = 4;
  localparam int CS_LIMIT  = 99;
  localparam int SEC_LIMIT = 59;
  localparam int MIN_LIMIT = 59;

  // Converts a small decimal constant (0..99) into its two-digit BCD form.
  function automatic logic [2*BCD_W-1:0] bcd_const(input int v);
    return {BCD_W'(v / 10), BCD_W'(v % 10)};
  endfunction

endpackage

// File: rtl/stopwatch_counter_bcd.sv
// Two-digit BCD modulo counter; wraps to 00 after MAX and flags the carry.
module bcd_mod_counter
  import stopwatch_pkg::*;
#(
  parameter int MAX = 59
) (
  input  logic               sys_clk,
  input  logic               reset_n,
  input  logic               inc,
  input  logic               zero,
  output logic [2*BCD_W-1:0] value,
  output logic               carry
);

  localparam logic [2*BCD_W-1:0] MAX_BCD = bcd_const(MAX);

  logic [BCD_W-1:0] tens;
  logic [BCD_W-1:0] units;
  logic             at_max;

  assign value  = {tens, units};
  assign at_max = (value == MAX_BCD);
  assign carry  = inc & at_max;

  // Digit update: zero has priority, then wrap at MAX, units 9->0 carries into tens.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      tens  <= '0;
      units <= '0;
    end else if (zero) begin
      tens  <= '0;
      units <= '0;
    end else if (inc) begin
      if (at_max) begin
        tens  <= '0;
        units <= '0;
      end else if (units == BCD_W'(9)) begin
        units <= '0;
        tens  <= tens + BCD_W'(1);
      end else begin
        units <= units + BCD_W'(1);
      end
    end
  end

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch stage: counts base_tick rising edges as centiseconds in BCD,
// runs the start/stop/lap/clear FSM and drives registered display values.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int CS_MAX  = CS_LIMIT,
  parameter int SEC_MAX = SEC_LIMIT,
  parameter int MIN_MAX = MIN_LIMIT
) (
  input  logic       sys_clk,
  input  logic       reset_n,
  input  logic       base_tick,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  output logic       timer_enb,
  output logic [7:0] disp_min,
  output logic [7:0] disp_sec,
  output logic [7:0] disp_cs,
  output logic       running,
  output logic       lap_active,
  output logic       overflow
);

  sw_state_t  state;
  sw_state_t  next_state;
  logic       base_tick_q;
  logic       tick;
  logic       count_inc;
  logic       zero_count;
  logic       clear_all;
  logic       take_snap;
  logic       lap_next;
  logic       cs_carry;
  logic       sec_carry;
  logic       min_carry;
  logic [7:0] live_min;
  logic [7:0] live_sec;
  logic [7:0] live_cs;
  logic [7:0] snap_min;
  logic [7:0] snap_sec;
  logic [7:0] snap_cs;

  assign tick      = base_tick & ~base_tick_q;
  assign count_inc = tick & (state == ST_RUN);

  // Capture register for rising-edge detection of base_tick.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) base_tick_q <= 1'b0;
    else          base_tick_q <= base_tick;
  end

  bcd_mod_counter #(.MAX(CS_MAX)) u_cs (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .inc     (count_inc),
    .zero    (zero_count),
    .value   (live_cs),
    .carry   (cs_carry)
  );

  bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .inc     (cs_carry),
    .zero    (zero_count),
    .value   (live_sec),
    .carry   (sec_carry)
  );

  bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .inc     (sec_carry),
    .zero    (zero_count),
    .value   (live_min),
    .carry   (min_carry)
  );

  // Control decisions; lap is judged against the state before any transition.
  always_comb begin
    next_state = state;
    lap_next   = lap_active;
    take_snap  = 1'b0;
    clear_all  = 1'b0;
    zero_count = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_stop) next_state = ST_RUN;
        if (clear)      zero_count = 1'b1;
      end
      ST_RUN: begin
        if (start_stop) next_state = ST_PAUSE;
        if (lap) begin
          lap_next  = ~lap_active;
          take_snap = ~lap_active;
        end
      end
      ST_PAUSE: begin
        if (clear) begin
          next_state = ST_IDLE;
          lap_next   = 1'b0;
          clear_all  = 1'b1;
          zero_count = 1'b1;
        end else begin
          if (start_stop)        next_state = ST_RUN;
          if (lap && lap_active) lap_next   = 1'b0;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  // Lap freeze flag and the snapshot taken when the freeze engages.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      lap_active <= 1'b0;
      snap_min   <= '0;
      snap_sec   <= '0;
      snap_cs    <= '0;
    end else begin
      lap_active <= lap_next;
      if (take_snap) begin
        snap_min <= live_min;
        snap_sec <= live_sec;
        snap_cs  <= live_cs;
      end
    end
  end

  // Sticky wrap flag, only released by a clear from PAUSE.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n)       overflow <= 1'b0;
    else if (clear_all) overflow <= 1'b0;
    else if (min_carry) overflow <= 1'b1;
  end

  // Run indicators registered from the current state.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      running   <= 1'b0;
      timer_enb <= 1'b0;
    end else begin
      running   <= (state == ST_RUN);
      timer_enb <= (state == ST_RUN);
    end
  end

  // Registered display: frozen snapshot while lap is active, else live count.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      disp_min <= '0;
      disp_sec <= '0;
      disp_cs  <= '0;
    end else if (lap_active) begin
      disp_min <= snap_min;
      disp_sec <= snap_sec;
      disp_cs  <= snap_cs;
    end else begin
      disp_min <= live_min;
      disp_sec <= live_sec;
      disp_cs  <= live_cs;
    end
  end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Self-checking bench for stopwatch_counter with an elapsed-time reference model.
module tb_stopwatch_counter;

  localparam int TB_CS  = 99;
  localparam int TB_SEC = 59;
  localparam int TB_MIN = 2;
  localparam int CS_N   = TB_CS + 1;
  localparam int SEC_N  = TB_SEC + 1;
  localparam int TOTAL  = CS_N * SEC_N * (TB_MIN + 1);

  logic       sys_clk = 1'b0;
  logic       reset_n;
  logic       base_tick;
  logic       start_stop;
  logic       lap;
  logic       clear;
  logic       timer_enb;
  logic [7:0] disp_min;
  logic [7:0] disp_sec;
  logic [7:0] disp_cs;
  logic       running;
  logic       lap_active;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  int mTime;
  int mSnap;
  bit mRun;
  bit mPause;
  bit mLap;
  bit mOvf;
  bit mPrevBt;

  stopwatch_counter #(
    .CS_MAX  (TB_CS),
    .SEC_MAX (TB_SEC),
    .MIN_MAX (TB_MIN)
  ) dut (
    .sys_clk    (sys_clk),
    .reset_n    (reset_n),
    .base_tick  (base_tick),
    .start_stop (start_stop),
    .lap        (lap),
    .clear      (clear),
    .timer_enb  (timer_enb),
    .disp_min   (disp_min),
    .disp_sec   (disp_sec),
    .disp_cs    (disp_cs),
    .running    (running),
    .lap_active (lap_active),
    .overflow   (overflow)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [7:0] toBcd(input int v);
    logic [3:0] t;
    logic [3:0] u;
    t = 4'((v / 10) % 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  task automatic modelReset();
    mTime = 0; mSnap = 0; mRun = 0; mPause = 0;
    mLap = 0; mOvf = 0; mPrevBt = 0;
  endtask

  task automatic modelStep(input bit ss, input bit lp, input bit clr, input bit bt);
    bit tk;
    int old;
    tk = bt && !mPrevBt;
    mPrevBt = bt;
    old = mTime;
    if (mRun) begin
      if (tk) begin
        mTime = mTime + 1;
        if (mTime == TOTAL) begin
          mTime = 0;
          mOvf = 1;
        end
      end
      if (lp) begin
        if (!mLap) mSnap = old;
        mLap = !mLap;
      end
      if (ss) begin
        mRun = 0;
        mPause = 1;
      end
    end else if (mPause) begin
      if (clr) begin
        mTime = 0; mLap = 0; mOvf = 0; mPause = 0;
      end else begin
        if (lp) mLap = 0;
        if (ss) begin
          mPause = 0;
          mRun = 1;
        end
      end
    end else begin
      if (ss) mRun = 1;
      if (clr) mTime = 0;
    end
  endtask

  task automatic applyStimulus(input bit ss, input bit lp, input bit clr, input bit bt);
    @(negedge sys_clk);
    start_stop = ss;
    lap        = lp;
    clear      = clr;
    base_tick  = bt;
    @(posedge sys_clk);
    modelStep(ss, lp, clr, bt);
  endtask

  task automatic checkVal(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    int dv;
    #1;
    dv = mLap ? mSnap : mTime;
    checkVal({tag, ".cs"},  disp_cs,  toBcd(dv % CS_N));
    checkVal({tag, ".sec"}, disp_sec, toBcd((dv / CS_N) % SEC_N));
    checkVal({tag, ".min"}, disp_min, toBcd(dv / (CS_N * SEC_N)));
    checkVal({tag, ".running"},   {7'd0, running},    {7'd0, mRun});
    checkVal({tag, ".timer_enb"}, {7'd0, timer_enb},  {7'd0, mRun});
    checkVal({tag, ".lap"},       {7'd0, lap_active}, {7'd0, mLap});
    checkVal({tag, ".overflow"},  {7'd0, overflow},   {7'd0, mOvf});
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, mPrevBt);
  endtask

  task automatic ticks(input int n);
    if (mPrevBt) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (n) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic settleCheck(input string tag);
    idle(2);
    checkOutput(tag);
  endtask

  initial begin
    reset_n = 1'b0; base_tick = 1'b0; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
    modelReset();
    #12;
    checkOutput("reset");
    @(negedge sys_clk);
    reset_n = 1'b1;
    settleCheck("idle");

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(150);
    settleCheck("run150");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(20);
    settleCheck("pausedHold");

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    ticks(50);
    settleCheck("resumeNoTick");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(50);
    settleCheck("lapFrozen");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    settleCheck("lapReleased");

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(3);
    settleCheck("clearInRun");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    settleCheck("clearSsInRun");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    settleCheck("clearSsInPause");

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(9);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    settleCheck("tickWithStop");

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(CS_N * SEC_N - 1);
    settleCheck("at0059_99");
    ticks(1);
    settleCheck("at0100_00");
    ticks(TOTAL - CS_N * SEC_N - 1);
    settleCheck("atLastValue");
    ticks(1);
    settleCheck("wrapOverflow");
    ticks(5);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    settleCheck("overflowSticky");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    settleCheck("overflowCleared");

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(347);
    idle(2);
    #2;
    reset_n = 1'b0;
    modelReset();
    checkOutput("asyncReset");
    @(negedge sys_clk);
    reset_n = 1'b1;
    settleCheck("afterReset");

    for (int it = 0; it < 40; it++) begin
      int len;
      len = $urandom_range(1, 24);
      for (int c = 0; c < len; c++) begin
        applyStimulus($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                      $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)));
      end
      settleCheck("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
